// File: rtl/lfsr_noise_sequencer_pkg.sv
// Shared types and constants for the noise LFSR sequencer.
// State encoding, default seed and seed substitution helper.
package lfsr_noise_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_FLUSH = 3'd4
  } seq_state_t;

  localparam logic [31:0] SEED_DEFAULT_VAL = 32'h0000_0001;

  // An all-zero seed would lock the LFSR, so swap in a default.
  function automatic logic [31:0] seed_fix(
    input logic [31:0] s,
    input logic [31:0] dflt
  );
    return (s == '0) ? dflt : s;
  endfunction

endpackage

// File: rtl/lfsr_noise_sequencer.sv
// Drives clear/load/advance for the 32-bit noise LFSR.
// Handles start delay, bursts, continuous mode, reseed and abort.
module lfsr_noise_sequencer
  import lfsr_noise_sequencer_pkg::*;
#(
  parameter int          WORD_BITS    = 32,
  parameter int          CNT_W        = 16,
  parameter logic [31:0] SEED_DEFAULT = SEED_DEFAULT_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I_start,
  input  logic             I_stop,
  input  logic             I_reload,
  input  logic [31:0]      I_seed,
  input  logic [CNT_W-1:0] I_start_delay,
  input  logic [CNT_W-1:0] I_burst_len,
  output logic             O_lfsr_reset,
  output logic             O_lfsr_load,
  output logic [31:0]      O_lfsr_seed,
  output logic             O_lfsr_next,
  output logic             O_noise_valid,
  output logic             O_busy,
  output logic             O_done,
  output logic [CNT_W-1:0] O_word_count
);

  localparam int BW = $clog2(WORD_BITS);
  localparam logic [BW-1:0] BLAST = BW'(WORD_BITS - 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] dcnt, dcnt_nxt;
  logic [CNT_W-1:0] burst, burst_nxt;
  logic [CNT_W-1:0] wcnt_nxt;
  logic [BW-1:0]    bcnt, bcnt_nxt;
  logic [31:0]      seed_nxt;
  logic             budget_hit;
  logic             pulse;

  assign budget_hit = (burst != '0) && (O_word_count == burst);

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    burst_nxt = burst;
    seed_nxt  = O_lfsr_seed;
    wcnt_nxt  = O_word_count;
    bcnt_nxt  = '0;
    pulse     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (I_start && !I_stop) begin
          seed_nxt  = seed_fix(I_seed, SEED_DEFAULT);
          dcnt_nxt  = I_start_delay;
          burst_nxt = I_burst_len;
          wcnt_nxt  = '0;
          state_nxt = (I_start_delay != '0) ? S_DELAY : S_LOAD;
        end
      end
      S_DELAY: begin
        if (I_stop)
          state_nxt = S_FLUSH;
        else if (dcnt <= CNT_W'(1))
          state_nxt = S_LOAD;
        else
          dcnt_nxt = dcnt - CNT_W'(1);
      end
      // A reseed after the last word must not start an extra one.
      S_LOAD: begin
        if (I_stop || budget_hit)
          state_nxt = S_FLUSH;
        else
          state_nxt = S_RUN;
      end
      S_RUN: begin
        if (I_stop)
          state_nxt = S_FLUSH;
        else if (budget_hit && bcnt == BLAST)
          state_nxt = S_FLUSH;
        else if (I_reload) begin
          seed_nxt  = seed_fix(I_seed, SEED_DEFAULT);
          state_nxt = S_LOAD;
        end else
          bcnt_nxt = (bcnt == BLAST) ? '0 : bcnt + BW'(1);
      end
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_RUN && bcnt_nxt == '0) begin
      pulse    = 1'b1;
      wcnt_nxt = O_word_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      dcnt          <= '0;
      burst         <= '0;
      bcnt          <= '0;
      O_word_count  <= '0;
      O_lfsr_seed   <= '0;
      O_lfsr_reset  <= 1'b0;
      O_lfsr_load   <= 1'b0;
      O_lfsr_next   <= 1'b0;
      O_noise_valid <= 1'b0;
      O_busy        <= 1'b0;
      O_done        <= 1'b0;
    end else begin
      state         <= state_nxt;
      dcnt          <= dcnt_nxt;
      burst         <= burst_nxt;
      bcnt          <= bcnt_nxt;
      O_word_count  <= wcnt_nxt;
      O_lfsr_seed   <= seed_nxt;
      O_lfsr_reset  <= (state_nxt == S_FLUSH);
      O_lfsr_load   <= (state_nxt == S_LOAD);
      O_lfsr_next   <= pulse;
      O_noise_valid <= (state_nxt == S_RUN);
      O_busy        <= (state_nxt != S_IDLE);
      O_done        <= (state_nxt == S_FLUSH);
    end
  end

endmodule
